// File: rtl/video_ctrl_top.sv
// LCD/VGA timing generator with a grid or solid-colour test pattern and a heartbeat LED.
// Pixel rate is half the system clock, driven by an internal clock enable.
module video_ctrl_top #(
  parameter int unsigned HDISP  = 800,
  parameter int unsigned VDISP  = 480,
  parameter int unsigned HFP    = 40,
  parameter int unsigned HPULSE = 48,
  parameter int unsigned HBP    = 40,
  parameter int unsigned VFP    = 13,
  parameter int unsigned VPULSE = 3,
  parameter int unsigned VBP    = 29,
  parameter int unsigned GRID   = 16,
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        FPGA_CLK1_50,
  input  logic        reset,
  input  logic [1:0]  KEY,
  input  logic [3:0]  SW,
  output logic [7:0]  LED,
  output logic        video_CLK,
  output logic        video_HS,
  output logic        video_VS,
  output logic        video_BLANK,
  output logic [23:0] video_RGB
);

  localparam int unsigned HTOT = HDISP + HFP + HPULSE + HBP;
  localparam int unsigned VTOT = VDISP + VFP + VPULSE + VBP;
  localparam int unsigned XW   = $clog2(HTOT);
  localparam int unsigned YW   = $clog2(VTOT);
  localparam int unsigned GW   = $clog2(GRID);
  localparam int unsigned HALF = CLK_HZ / 2;
  localparam int unsigned DW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(HTOT - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(VTOT - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);

  logic          r_pe;
  logic          r_vclk;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  logic [23:0]   r_rgb;
  logic [DW-1:0] r_div;
  logic          r_led;

  logic          w_x_last;
  logic          w_y_last;
  logic [XW-1:0] w_x_next;
  logic [YW-1:0] w_y_next;
  logic          w_active;
  logic          w_hs;
  logic          w_vs;
  logic          w_grid;
  logic [23:0]   w_rgb;
  logic          w_unused;

  assign w_unused = ^{KEY, SW[3:1]};

  always_comb begin
    w_x_last = (r_x == X_LAST);
    w_y_last = (r_y == Y_LAST);
    w_x_next = w_x_last ? '0 : r_x + 1'b1;
    w_y_next = r_y;
    if (w_x_last) begin
      w_y_next = w_y_last ? '0 : r_y + 1'b1;
    end
    // 32-bit compares so porch boundaries equal to HTOT/VTOT cannot alias.
    w_active = (32'(r_x) < HDISP) && (32'(r_y) < VDISP);
    w_hs = !((32'(r_x) >= HDISP + HFP) && (32'(r_x) < HDISP + HFP + HPULSE));
    w_vs = !((32'(r_y) >= VDISP + VFP) && (32'(r_y) < VDISP + VFP + VPULSE));
    w_grid = (r_x[GW-1:0] == '0) || (r_y[GW-1:0] == '0);
    w_rgb  = 24'h000000;
    if (w_active) begin
      if (SW[0]) begin
        w_rgb = 24'h0000FF;
      end else if (w_grid) begin
        w_rgb = 24'hFFFFFF;
      end
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_pe    <= 1'b0;
      r_vclk  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_blank <= 1'b0;
      r_rgb   <= 24'h000000;
    end else begin
      r_pe   <= ~r_pe;
      r_vclk <= ~r_pe;
      // Outputs decode the counter value present on this enabled edge.
      if (r_pe) begin
        r_x     <= w_x_next;
        r_y     <= w_y_next;
        r_hs    <= w_hs;
        r_vs    <= w_vs;
        r_blank <= w_active;
        r_rgb   <= w_rgb;
      end
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_led <= 1'b0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_led <= ~r_led;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign LED         = {7'b0000000, r_led};
  assign video_CLK   = r_vclk;
  assign video_HS    = r_hs;
  assign video_VS    = r_vs;
  assign video_BLANK = r_blank;
  assign video_RGB   = r_rgb;

endmodule

// File: tb/tb_video_ctrl_top.sv
// Randomized bench for video_ctrl_top: every output is compared each clock against a
// raster model computed from the clock count since reset release.
module tb_video_ctrl_top;

  localparam int HDISP = 40, VDISP = 20, HFP = 4, HPULSE = 6, HBP = 5;
  localparam int VFP = 3, VPULSE = 2, VBP = 4, GRID = 8, CLK_HZ = 100;
  localparam int HTOT = HDISP + HFP + HPULSE + HBP;
  localparam int VTOT = VDISP + VFP + VPULSE + VBP;
  localparam int FRAME_CLK = 2 * HTOT * VTOT;

  logic        clk;
  logic        rst;
  logic [1:0]  key;
  logic [3:0]  sw;
  logic [7:0]  led;
  logic        vclk, hs, vs, blank;
  logic [23:0] rgb;

  int n_checks = 0;
  int n_errors = 0;
  int n_edge   = 0;  // clock edges since reset release
  bit m_sw     = 1'b0;

  video_ctrl_top #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .GRID(GRID), .CLK_HZ(CLK_HZ)
  ) u_dut (
    .FPGA_CLK1_50(clk),
    .reset       (rst),
    .KEY         (key),
    .SW          (sw),
    .LED         (led),
    .video_CLK   (vclk),
    .video_HS    (hs),
    .video_VS    (vs),
    .video_BLANK (blank),
    .video_RGB   (rgb)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Pixel k (1-based) is shown after the 2k-th edge; its switch value is the one seen then.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_edge = 0;
    end else begin
      n_edge++;
      if (n_edge % 2 == 0) m_sw = sw[0];
    end
  end

  function automatic logic [35:0] expect_vec(input int n, input bit s);
    logic hs_e = 1'b1, vs_e = 1'b1, bl_e = 1'b0, vc_e, led_e;
    logic [23:0] rgb_e = 24'h0;
    int k = n / 2;
    if (k > 0) begin
      int p = k - 1;
      int x = p % HTOT;
      int y = (p / HTOT) % VTOT;
      hs_e = !(x >= HDISP + HFP && x < HDISP + HFP + HPULSE);
      vs_e = !(y >= VDISP + VFP && y < VDISP + VFP + VPULSE);
      bl_e = (x < HDISP) && (y < VDISP);
      if (bl_e) rgb_e = s ? 24'h0000FF : ((x % GRID == 0 || y % GRID == 0) ? 24'hFFFFFF : 24'h0);
    end
    vc_e  = 1'(n % 2);
    led_e = 1'((n / (CLK_HZ / 2)) % 2);
    return {hs_e, vs_e, bl_e, rgb_e, vc_e, 7'b0, led_e};
  endfunction

  always @(negedge clk) begin
    int k, x, y;
    check("pix", 64'({hs, vs, blank, rgb, vclk, led}), 64'(expect_vec(n_edge, m_sw)));
    k = n_edge / 2;
    if (k > 0 && !rst && !m_sw) begin
      x = (k - 1) % HTOT;
      y = ((k - 1) / HTOT) % VTOT;
      if ((x == 16 && y == 5) || (x == 5 && y == 16)) check("grid_white", 64'(rgb), 64'hFFFFFF);
      if (x == 5 && y == 5) check("grid_black", 64'(rgb), 64'h0);
    end
  end

  task automatic run_frame(input bit rand_sw);
    for (int i = 0; i < FRAME_CLK; i++) begin
      @(negedge clk);
      if (rand_sw && $urandom_range(0, 99) == 0) sw = 4'($urandom);
      key = 2'($urandom);
    end
  endtask

  initial begin
    int n_bl, n_hs, n_vs;
    bit found;
    rst = 1'b1;
    sw  = 4'h0;
    key = 2'b11;
    #3;
    check("reset_vec", 64'({hs, vs, blank, rgb, vclk, led}), 64'({3'b110, 24'h0, 1'b0, 8'h0}));
    repeat (4) @(negedge clk);
    rst = 1'b0;
    run_frame(1'b0);

    n_bl = 0; n_hs = 0; n_vs = 0;
    for (int i = 0; i < FRAME_CLK; i++) begin
      @(negedge clk);
      #1;
      n_bl += int'(blank);
      n_hs += int'(!hs);
      n_vs += int'(!vs);
    end
    check("blank_clks", 64'(n_bl), 64'(2 * HDISP * VDISP));
    check("hs_low_clks", 64'(n_hs), 64'(2 * HPULSE * VTOT));
    check("vs_low_clks", 64'(n_vs), 64'(2 * VPULSE * HTOT));

    sw = 4'h1;
    run_frame(1'b0);
    run_frame(1'b1);

    // Reset mid-line at pixel (30,10): outputs must return to reset values immediately.
    sw = 4'h0;
    found = 1'b0;
    for (int i = 0; i < FRAME_CLK && !found; i++) begin
      @(negedge clk);
      if (n_edge >= 2 && ((n_edge / 2 - 1) % HTOT) == 30
          && (((n_edge / 2 - 1) / HTOT) % VTOT) == 10) found = 1'b1;
    end
    check("wait_pix_30_10", 64'(found), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 64'({hs, vs, blank, rgb, vclk, led}), 64'({3'b110, 24'h0, 1'b0, 8'h0}));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_frame(1'b0);
    run_frame(1'b1);

    // One more reset at a random point.
    repeat ($urandom_range(1, FRAME_CLK)) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst2", 64'({hs, vs, blank, rgb}), 64'({3'b110, 24'h0}));
    @(negedge clk);
    rst = 1'b0;
    run_frame(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
